alu_share_ctrl: RTL

- Sequencer/arbiter that shares one combinational Hack-style ALU between two requesters (A, B).
- Arbitrates between valid requests, latches the winner's operands and 6-bit control word, and drives the shared ALU for one cycle.
- Captures out/zr/ng and returns them on a single response channel tagged with the requester id.
- Sits between the CPU control unit (A) and the auxiliary/debug datapath (B) and the single ALU instance.

---
 rtl/alu_share_ctrl_if.sv | 65 ++++++
 rtl/alu_share_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl_if
// Description : Bundles the requester A/B channels, the shared-ALU drive and
//               return signals, and the response channel of alu_share_ctrl.
//               The slave modport is the controller's view; the master
//               modport is the view of the surrounding logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_ctrl_if #(
    parameter int WIDTH = 16
);
    // Requester A
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_x;
    logic [WIDTH-1:0] a_y;
    logic [5:0]       a_ctrl;
    // Requester B
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH-1:0] b_y;
    logic [5:0]       b_ctrl;
    // Shared ALU
    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic [5:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zr;
    logic             alu_ng;
    // Response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_out;
    logic             rsp_zr;
    logic             rsp_ng;
    logic             busy;

    modport slave (
        input  a_valid, a_x, a_y, a_ctrl,
        output a_ready,
        input  b_valid, b_x, b_y, b_ctrl,
        output b_ready,
        output alu_x, alu_y, alu_ctrl,
        input  alu_out, alu_zr, alu_ng,
        output rsp_valid, rsp_id, rsp_out, rsp_zr, rsp_ng,
        input  rsp_ready,
        output busy
    );

    modport master (
        output a_valid, a_x, a_y, a_ctrl,
        input  a_ready,
        output b_valid, b_x, b_y, b_ctrl,
        input  b_ready,
        input  alu_x, alu_y, alu_ctrl,
        output alu_out, alu_zr, alu_ng,
        input  rsp_valid, rsp_id, rsp_out, rsp_zr, rsp_ng,
        output rsp_ready,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Shares one combinational Hack-style ALU between requester A
//               (CPU control unit) and requester B (aux/debug datapath).
//               IDLE -> EXEC -> RESP -> IDLE; the winner's operands are
//               latched, driven to the ALU for one cycle, and the result is
//               returned on a single response channel tagged with its id.
//               Build option: define ALU_SHARE_RR_EN for round-robin
//               tie-break; otherwise A always wins a tie.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl #(
    parameter int WIDTH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_share_ctrl_if.slave  bus
);

    localparam logic c_ID_A = 1'b0;
    localparam logic c_ID_B = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [5:0]       ctrl_q, ctrl_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
    logic             rsp_zr_q, rsp_zr_d;
    logic             rsp_ng_q, rsp_ng_d;

    logic             w_idle;
    logic             w_tie_to_b;
    logic             w_grant_a;
    logic             w_grant_b;

    // Grant selection: a lone requester always wins; a tie goes by build option
    always_comb begin
        w_idle = (state_q == S_IDLE);
`ifdef ALU_SHARE_RR_EN
        w_tie_to_b = (last_grant_q == c_ID_A);
`else
        // History register is kept in both builds; fixed priority ignores it.
        w_tie_to_b = last_grant_q & 1'b0;
`endif
        w_grant_a = w_idle & bus.a_valid & (~bus.b_valid | ~w_tie_to_b);
        w_grant_b = w_idle & bus.b_valid & (~bus.a_valid |  w_tie_to_b);
    end

    // Next-state and next-register computation for the sequencer
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        ctrl_d       = ctrl_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_out_d    = rsp_out_q;
        rsp_zr_d     = rsp_zr_q;
        rsp_ng_d     = rsp_ng_q;
        case (state_q)
            S_IDLE: begin
                if (w_grant_a) begin
                    x_d          = bus.a_x;
                    y_d          = bus.a_y;
                    ctrl_d       = bus.a_ctrl;
                    id_d         = c_ID_A;
                    last_grant_d = c_ID_A;
                    state_d      = S_EXEC;
                end else if (w_grant_b) begin
                    x_d          = bus.b_x;
                    y_d          = bus.b_y;
                    ctrl_d       = bus.b_ctrl;
                    id_d         = c_ID_B;
                    last_grant_d = c_ID_B;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                // ALU has had the latched operands for the whole cycle
                rsp_out_d   = bus.alu_out;
                rsp_zr_d    = bus.alu_zr;
                rsp_ng_d    = bus.alu_ng;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            ctrl_q       <= '0;
            id_q         <= c_ID_A;
            last_grant_q <= c_ID_B;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= c_ID_A;
            rsp_out_q    <= '0;
            rsp_zr_q     <= 1'b0;
            rsp_ng_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            ctrl_q       <= ctrl_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_out_q    <= rsp_out_d;
            rsp_zr_q     <= rsp_zr_d;
            rsp_ng_q     <= rsp_ng_d;
        end
    end

    assign bus.a_ready   = w_grant_a;
    assign bus.b_ready   = w_grant_b;
    assign bus.alu_x     = x_q;
    assign bus.alu_y     = y_q;
    assign bus.alu_ctrl  = ctrl_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_zr    = rsp_zr_q;
    assign bus.rsp_ng    = rsp_ng_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
